// File: rtl/weight_spad_reader.sv
// weight_spad_reader: read-side sequencer for the PE weight scratchpad.
// Walks a window [base, base+length) of the scratchpad (wrapping mod depth),
// repeating the window 'repeats' times, and streams the captured weights to
// the MAC over a valid/ready handshake with a per-pass last flag.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, base_addr, length, repeats   job command (sampled in IDLE)
//   abort                    synchronous job cancel
//   spad_r_en, spad_read_address, spad_read_data   scratchpad read port
//   w_data, w_valid, w_ready, w_last                weight stream to MAC
//   busy, done               job status
module weight_spad_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned REP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [REP_W-1:0]  repeats,
    input  logic              abort,
    output logic              spad_r_en,
    output logic [ADDR_W-1:0] spad_read_address,
    input  logic [DATA_W-1:0] spad_read_data,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [IDX_W-1:0]    r_len;
    logic [REP_W-1:0]    r_rep;
    logic [IDX_W-1:0]    r_idx;
    logic [REP_W-1:0]    r_pass;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_w_data;
    logic                r_w_valid;
    logic                r_w_last;

    logic                w_issue;
    logic                w_idx_last;
    logic                w_final;
    logic                w_abort;
    logic [ADDR_W-1:0]   w_addr_sum;

    // A read is issued only when the output register is free or draining this cycle.
    assign w_issue    = (r_state == S_RUN) && (!r_w_valid || w_ready);
    assign w_idx_last = (r_idx == (r_len - IDX_W'(1)));
    assign w_final    = w_idx_last && (r_pass == (r_rep - REP_W'(1)));
    assign w_abort    = abort && (r_state != S_IDLE);
    // Carry dropped: the window wraps from the top address back to 0.
    assign w_addr_sum = r_base + r_idx[ADDR_W-1:0];

    assign spad_r_en         = w_issue;
    // Address is live during an issue cycle (read data is combinational), held otherwise.
    assign spad_read_address = w_issue ? w_addr_sum : r_addr;
    assign w_data            = r_w_data;
    assign w_valid           = r_w_valid;
    assign w_last            = r_w_last;
    assign busy              = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done              = (r_state == S_DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides every transition outside IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if ((length == '0) || (repeats == '0)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_issue && w_final) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_w_valid && w_ready) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Job configuration and window walk counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base <= '0;
            r_len  <= '0;
            r_rep  <= '0;
            r_idx  <= '0;
            r_pass <= '0;
            r_addr <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_base <= base_addr;
                r_len  <= length;
                r_rep  <= repeats;
                r_idx  <= '0;
                r_pass <= '0;
            end
        end else if (w_issue && !w_abort) begin
            r_addr <= w_addr_sum;
            if (w_idx_last) begin
                r_idx  <= '0;
                r_pass <= r_pass + REP_W'(1);
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
            end
        end
    end

    // Output register: capture on issue, retire on handshake, hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_data  <= '0;
            r_w_valid <= 1'b0;
            r_w_last  <= 1'b0;
        end else if (w_abort) begin
            r_w_valid <= 1'b0;
            r_w_last  <= 1'b0;
        end else if (w_issue) begin
            r_w_data  <= spad_read_data;
            r_w_valid <= 1'b1;
            r_w_last  <= w_idx_last;
        end else if (r_w_valid && w_ready) begin
            r_w_valid <= 1'b0;
            r_w_last  <= 1'b0;
        end
    end

endmodule
